// File: rtl/traffic_phase_fsm.sv
// traffic_phase_fsm: pedestrian-crossing phase sequencer stepped by a synchronized 1 Hz tick.
// Build macro PED_PRIORITY_EN: a latched request may cut car green short once T_MIN_GREEN seconds have elapsed.
module traffic_phase_fsm #(
  parameter int unsigned T_GREEN     = 20,
  parameter int unsigned T_MIN_GREEN = 5,
  parameter int unsigned T_YELLOW    = 3,
  parameter int unsigned T_ALL_RED   = 1,
  parameter int unsigned T_WALK      = 10,
  parameter int unsigned T_CLEAR     = 4
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       clk_1Hz,
  input  logic       ped_btn,
  output logic       car_red,
  output logic       car_yellow,
  output logic       car_green,
  output logic       ped_walk,
  output logic       ped_dont_walk,
  output logic       ped_wait,
  output logic [7:0] sec_left
);

  typedef enum logic [2:0] {
    CAR_GREEN,
    CAR_YELLOW,
    ALL_RED1,
    PED_WALK,
    PED_CLEAR,
    ALL_RED2
  } phase_t;

  localparam logic [7:0] GREEN_SECS     = 8'(T_GREEN);
  localparam logic [7:0] YELLOW_SECS    = 8'(T_YELLOW);
  localparam logic [7:0] ALL_RED_SECS   = 8'(T_ALL_RED);
  localparam logic [7:0] WALK_SECS      = 8'(T_WALK);
  localparam logic [7:0] CLEAR_SECS     = 8'(T_CLEAR);
  localparam logic [8:0] MIN_GREEN_SECS = 9'(T_MIN_GREEN);

`ifdef PED_PRIORITY_EN
  localparam bit PRIORITY_EN = 1'b1;
`else
  localparam bit PRIORITY_EN = 1'b0;
`endif

  // Bit 0 is the 1 Hz divider output, bit 1 the push-button; both are asynchronous.
  logic [1:0] async_in;
  logic [1:0] async_rise;

  assign async_in = {ped_btn, clk_1Hz};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      logic prev_reg;

      always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
          prev_reg <= 1'b0;
        end else begin
          meta_reg <= async_in[gi];
          sync_reg <= meta_reg;
          prev_reg <= sync_reg;
        end
      end

      assign async_rise[gi] = sync_reg & ~prev_reg;
    end
  endgenerate

  logic tick;
  logic btn_rise;

  assign tick     = async_rise[0];
  assign btn_rise = async_rise[1];

  phase_t     state_reg, state_next;
  logic [7:0] sec_left_reg, sec_left_next;
  logic       req_reg, req_next;
  logic [8:0] green_elapsed;
  logic       min_green_met;

  function automatic logic [7:0] phase_secs(input phase_t p);
    case (p)
      CAR_GREEN:  phase_secs = GREEN_SECS;
      CAR_YELLOW: phase_secs = YELLOW_SECS;
      ALL_RED1:   phase_secs = ALL_RED_SECS;
      PED_WALK:   phase_secs = WALK_SECS;
      PED_CLEAR:  phase_secs = CLEAR_SECS;
      default:    phase_secs = ALL_RED_SECS;
    endcase
  endfunction

  function automatic phase_t phase_after(input phase_t p);
    case (p)
      CAR_GREEN:  phase_after = CAR_YELLOW;
      CAR_YELLOW: phase_after = ALL_RED1;
      ALL_RED1:   phase_after = PED_WALK;
      PED_WALK:   phase_after = PED_CLEAR;
      PED_CLEAR:  phase_after = ALL_RED2;
      default:    phase_after = CAR_GREEN;
    endcase
  endfunction

  // Seconds of green already shown, counting the second that ends on this tick.
  assign green_elapsed = {1'b0, GREEN_SECS} - {1'b0, sec_left_reg} + 9'd1;
  assign min_green_met = (green_elapsed >= MIN_GREEN_SECS);

  always_comb begin
    state_next    = state_reg;
    sec_left_next = sec_left_reg;
    req_next      = req_reg;

    if (tick) begin
      case (state_reg)
        CAR_GREEN: begin
          if (req_reg && ((sec_left_reg == 8'd1) || (PRIORITY_EN && min_green_met))) begin
            state_next = CAR_YELLOW;
          end else if (sec_left_reg == 8'd1) begin
            sec_left_next = GREEN_SECS;
          end else begin
            sec_left_next = sec_left_reg - 8'd1;
          end
        end
        default: begin
          if (sec_left_reg == 8'd1) begin
            state_next = phase_after(state_reg);
          end else begin
            sec_left_next = sec_left_reg - 8'd1;
          end
        end
      endcase
    end

    if (state_next != state_reg) begin
      sec_left_next = phase_secs(state_next);
    end

    // Entering the walk phase services the request and wins over a simultaneous press.
    if ((state_next == PED_WALK) && (state_reg != PED_WALK)) begin
      req_next = 1'b0;
    end else if (btn_rise && (state_reg != PED_WALK)) begin
      req_next = 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_reg     <= CAR_GREEN;
      sec_left_reg  <= GREEN_SECS;
      req_reg       <= 1'b0;
      car_red       <= 1'b0;
      car_yellow    <= 1'b0;
      car_green     <= 1'b1;
      ped_walk      <= 1'b0;
      ped_dont_walk <= 1'b1;
    end else begin
      state_reg     <= state_next;
      sec_left_reg  <= sec_left_next;
      req_reg       <= req_next;
      car_green     <= (state_next == CAR_GREEN);
      car_yellow    <= (state_next == CAR_YELLOW);
      car_red       <= (state_next != CAR_GREEN) && (state_next != CAR_YELLOW);
      ped_walk      <= (state_next == PED_WALK);
      ped_dont_walk <= (state_next != PED_WALK);
    end
  end

  assign ped_wait = req_reg;
  assign sec_left = sec_left_reg;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Scoreboard bench for traffic_phase_fsm: a phase model pushes expected lamps/counters per stimulus,
// popped and compared once the DUT has settled.
module tb_traffic_phase_fsm;

`ifdef PED_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  localparam int TG = 6, TMG = 2, TY = 2, TAR = 1, TW = 3, TC = 2;

  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b1;
  logic       clk_1Hz = 1'b0;
  logic       ped_btn = 1'b0;
  logic       car_red, car_yellow, car_green, ped_walk, ped_dont_walk, ped_wait;
  logic [7:0] sec_left;

  traffic_phase_fsm #(
    .T_GREEN(TG), .T_MIN_GREEN(TMG), .T_YELLOW(TY),
    .T_ALL_RED(TAR), .T_WALK(TW), .T_CLEAR(TC)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .clk_1Hz(clk_1Hz), .ped_btn(ped_btn),
    .car_red(car_red), .car_yellow(car_yellow), .car_green(car_green),
    .ped_walk(ped_walk), .ped_dont_walk(ped_dont_walk), .ped_wait(ped_wait),
    .sec_left(sec_left)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int assert_cnt = 0;
  int fail_cnt = 0;

  task automatic check_val(input string tag, input int actual, input int expected);
    assert_cnt++;
    if (actual != expected) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Phase model: 0 green, 1 yellow, 2 all-red1, 3 walk, 4 clear, 5 all-red2
  typedef struct {int r; int y; int g; int w; int dw; int pw; int sec;} exp_t;
  exp_t sb_q[$];
  int   m_state, m_sec, m_req;
  int   txn = 0;

  function automatic int dur(input int s);
    case (s)
      0: dur = TG;
      1: dur = TY;
      3: dur = TW;
      4: dur = TC;
      default: dur = TAR;
    endcase
  endfunction

  task automatic push_expected();
    exp_t e;
    e.g  = (m_state == 0);
    e.y  = (m_state == 1);
    e.r  = (m_state >= 2);
    e.w  = (m_state == 3);
    e.dw = (m_state != 3);
    e.pw = m_req;
    e.sec = m_sec;
    sb_q.push_back(e);
  endtask

  task automatic model_reset();
    m_state = 0; m_sec = TG; m_req = 0;
  endtask

  task automatic model_tick(input bit press);
    int  nxt;
    bool_leave: begin
      nxt = m_state;
      if (m_state == 0) begin
        if (m_req != 0 && (m_sec == 1 || (PRIO && (TG - m_sec + 1) >= TMG))) nxt = 1;
      end else if (m_sec == 1) begin
        nxt = (m_state + 1) % 6;
      end
    end
    if (nxt != m_state || m_sec == 1) m_sec = dur(nxt);
    else m_sec = m_sec - 1;
    if (nxt == 3 && m_state != 3) m_req = 0;
    else if (press && m_state != 3) m_req = 1;
    m_state = nxt;
  endtask

  task automatic sb_compare();
    exp_t e;
    txn++;
    if (sb_q.size() == 0) begin
      check_val($sformatf("t%0d sb_empty", txn), 0, 1);
      return;
    end
    e = sb_q.pop_front();
    check_val($sformatf("t%0d car_red", txn), int'(car_red), e.r);
    check_val($sformatf("t%0d car_yellow", txn), int'(car_yellow), e.y);
    check_val($sformatf("t%0d car_green", txn), int'(car_green), e.g);
    check_val($sformatf("t%0d ped_walk", txn), int'(ped_walk), e.w);
    check_val($sformatf("t%0d ped_dont_walk", txn), int'(ped_dont_walk), e.dw);
    check_val($sformatf("t%0d ped_wait", txn), int'(ped_wait), e.pw);
    check_val($sformatf("t%0d sec_left", txn), int'(sec_left), e.sec);
    $display("txn %0d: state=%0d sec_left=%0d ped_wait=%0d lamps r/y/g=%0d%0d%0d walk/dw=%0d%0d",
             txn, m_state, sec_left, ped_wait, car_red, car_yellow, car_green, ped_walk, ped_dont_walk);
  endtask

  // One 1 Hz period; optionally a button edge raised on the same clock as the 1 Hz edge.
  task automatic do_tick(input bit press);
    @(negedge clk_100MHz);
    clk_1Hz = 1'b1;
    if (press) ped_btn = 1'b1;
    model_tick(press);
    push_expected();
    repeat (5) @(negedge clk_100MHz);
    clk_1Hz = 1'b0;
    ped_btn = 1'b0;
    repeat (4) @(negedge clk_100MHz);
    sb_compare();
  endtask

  task automatic do_press();
    @(negedge clk_100MHz);
    ped_btn = 1'b1;
    if (m_state != 3) m_req = 1;
    push_expected();
    repeat (4) @(negedge clk_100MHz);
    ped_btn = 1'b0;
    repeat (4) @(negedge clk_100MHz);
    sb_compare();
  endtask

  task automatic apply_reset();
    @(negedge clk_100MHz);
    reset = 1'b1;
    model_reset();
    push_expected();
    repeat (3) @(negedge clk_100MHz);
    sb_compare();
    reset = 1'b0;
    repeat (2) @(negedge clk_100MHz);
  endtask

  task automatic run_until(input int target, input string tag);
    int n = 0;
    while (m_state != target && n < 30) begin
      do_tick(1'b0);
      n++;
    end
    check_val(tag, int'(m_state == target), 1);
  endtask

  // Exactly one car lamp and one pedestrian lamp on every cycle.
  bit mon_en = 1'b0;
  always @(negedge clk_100MHz) begin
    if (mon_en)
      check_val("lamp_onehot", (int'(car_red) + int'(car_yellow) + int'(car_green)) * 10
                + int'(ped_walk) + int'(ped_dont_walk), 11);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_y, first_w, first_dw, first_g;

    // Reset state while reset is held
    repeat (3) @(negedge clk_100MHz);
    mon_en = 1'b1;
    apply_reset();

    // No button: green held, counter wraps every 6 ticks
    for (int i = 0; i < 14; i++) begin
      do_tick(1'b0);
      check_val($sformatf("idle%0d car_green", i + 1), int'(car_green), 1);
    end

    // Press after tick 1, track when each phase appears
    apply_reset();
    do_tick(1'b0);
    do_press();
    check_val("press ped_wait", int'(ped_wait), 1);
    first_y = 0; first_w = 0; first_dw = 0; first_g = 0;
    for (int i = 2; i <= 16; i++) begin
      do_tick(1'b0);
      if (car_yellow && first_y == 0) first_y = i;
      if (ped_walk && first_w == 0) begin
        first_w = i;
        check_val("walk ped_wait", int'(ped_wait), 0);
      end
      if (first_w != 0 && ped_dont_walk && first_dw == 0) first_dw = i;
      if (first_y != 0 && car_green && first_g == 0) first_g = i;
    end
    check_val("first_yellow_tick", first_y, PRIO ? 2 : 6);
    check_val("first_walk_tick", first_w, PRIO ? 5 : 9);
    check_val("dont_walk_tick", first_dw, PRIO ? 8 : 12);
    check_val("green_return_tick", first_g, PRIO ? 11 : 15);

    // Press during walk is ignored; green then runs full reloads
    apply_reset();
    do_press();
    run_until(3, "reach_walk_a");
    do_press();
    check_val("walk_press ped_wait", int'(ped_wait), 0);
    run_until(0, "reach_green_a");
    for (int i = 0; i < 7; i++) begin
      do_tick(1'b0);
      check_val($sformatf("full_green%0d", i), int'(car_green), 1);
    end

    // Press during clear is held and serviced on the next cycle
    do_press();
    run_until(4, "reach_clear");
    do_press();
    check_val("clear_press ped_wait", int'(ped_wait), 1);
    run_until(0, "reach_green_b");
    run_until(3, "reach_walk_b");

    // Button edge coincident with walk entry: clear wins
    apply_reset();
    do_press();
    run_until(2, "reach_allred1");
    do_tick(1'b1);
    check_val("coincident ped_walk", int'(ped_walk), 1);
    check_val("coincident ped_wait", int'(ped_wait), 0);

    // Asynchronous reset mid-walk
    do_tick(1'b0);
    @(negedge clk_100MHz);
    #2 reset = 1'b1;
    #1;
    check_val("async_rst car_green", int'(car_green), 1);
    check_val("async_rst car_red", int'(car_red), 0);
    check_val("async_rst ped_dont_walk", int'(ped_dont_walk), 1);
    check_val("async_rst ped_walk", int'(ped_walk), 0);
    check_val("async_rst ped_wait", int'(ped_wait), 0);
    check_val("async_rst sec_left", int'(sec_left), TG);
    model_reset();
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    do_tick(1'b0);
    do_tick(1'b0);

    check_val("sb_drained", sb_q.size(), 0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/traffic_phase_fsm.md
TRAFFIC_PHASE_FSM -- requirements
Module: traffic_phase_fsm

Interface
REQ-001 SHALL have parameter T_GREEN, default 20, car green duration in seconds (1..255).
REQ-002 SHALL have parameter T_MIN_GREEN, default 5, minimum car green before a pedestrian cut-short (1..T_GREEN).
REQ-003 SHALL have parameters T_YELLOW 3, T_ALL_RED 1, T_WALK 10, T_CLEAR 4, each a phase duration in seconds (1..255).
REQ-004 SHALL have port clk_100MHz, input, 1, system clock.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-high, and the clock is clk_100MHz.
REQ-006 SHALL have port clk_1Hz, input, 1, 50% duty 1 Hz square wave from the clock divider, asynchronous to this block's logic.
REQ-007 SHALL have port ped_btn, input, 1, raw pedestrian push-button, active-high.
REQ-008 SHALL have ports car_red, car_yellow, car_green, output, 1 each, car lamps.
REQ-009 SHALL have ports ped_walk, ped_dont_walk, output, 1 each, pedestrian lamps.
REQ-010 SHALL have port ped_wait, output, 1, high while a pedestrian request is latched.
REQ-011 SHALL have port sec_left, output, 8, seconds remaining in the current phase.

Function
REQ-012 SHALL pass clk_1Hz and ped_btn through separate 2-flop synchronizers clocked by clk_100MHz.
REQ-013 SHALL derive a one-cycle tick on each rising edge of synchronized clk_1Hz; registered outputs change on the 3rd clk_100MHz rising edge after clk_1Hz rises (±1 cycle sampling uncertainty).
REQ-014 SHALL implement states CAR_GREEN -> CAR_YELLOW -> ALL_RED1 -> PED_WALK -> PED_CLEAR -> ALL_RED2 -> CAR_GREEN.
REQ-015 SHALL load sec_left with the entered state's duration on every state entry; on each tick decrement it, or, when sec_left==1, transition instead; each phase lasts exactly its duration in ticks.
REQ-016 SHALL, in CAR_GREEN with sec_left==1 on a tick and no request latched, stay in CAR_GREEN and reload T_GREEN.
REQ-017 SHALL leave CAR_GREEN for CAR_YELLOW only when a request is latched.
REQ-018 SHALL set the request latch on a rising edge of synchronized ped_btn in any state except PED_WALK; presses during PED_WALK are ignored.
REQ-019 SHALL clear the request latch on entry to PED_WALK; a press in PED_CLEAR or ALL_RED2 is held for the next cycle.
REQ-020 SHALL, if a set and the PED_WALK-entry clear coincide, give the clear priority.
REQ-021 SHALL drive lamps decoded from state, registered, exactly one car lamp and one ped lamp high: car_green in CAR_GREEN, car_yellow in CAR_YELLOW, car_red otherwise; ped_walk in PED_WALK only, ped_dont_walk otherwise.
REQ-022 SHALL drive ped_wait equal to the request latch.

Reset
REQ-023 SHALL, while reset is high, asynchronously force state CAR_GREEN, sec_left=T_GREEN, car_green=1, car_yellow=0, car_red=0, ped_walk=0, ped_dont_walk=1, ped_wait=0, synchronizers and edge detectors cleared.
REQ-024 SHALL, on reset mid-phase, abandon the phase and drop any pending request; the first tick after release decrements from T_GREEN.

Configuration
REQ-025 SHALL honour macro PED_PRIORITY_EN: when defined, a tick in CAR_GREEN with a request latched and (T_GREEN - sec_left + 1) >= T_MIN_GREEN moves to CAR_YELLOW immediately.
REQ-026 SHALL, without PED_PRIORITY_EN, leave CAR_GREEN only on a tick with sec_left==1 and a request latched; T_MIN_GREEN is then unused.

Verification (T_GREEN=6, T_MIN_GREEN=2, T_YELLOW=2, T_ALL_RED=1, T_WALK=3, T_CLEAR=2; clk_1Hz driven fast by bench)
REQ-027 SHALL check: reset release, no button, 14 ticks -> car_green held throughout, sec_left 6,5,..,1,6,5,.. wrapping.
REQ-028 SHALL check: macro off, press after tick 1 -> ped_wait=1; yellow after tick 6, ALL_RED1 after tick 8, walk after tick 9 with ped_wait=0, dont_walk after tick 12, car_green after tick 15.
REQ-029 SHALL check: macro on, press after tick 1 -> car_yellow after tick 2 (elapsed=2), sequence otherwise as REQ-028.
REQ-030 SHALL check: press during PED_WALK -> ped_wait stays 0, next CAR_GREEN runs full 6-tick reloads; press during PED_CLEAR -> ped_wait=1 and next cycle serviced.
REQ-031 SHALL check: reset asserted mid-PED_WALK with request pending -> immediately car_green=1, ped_dont_walk=1, ped_wait=0, sec_left=6.
REQ-032 SHALL check: ped_btn edge coincident with PED_WALK entry -> ped_wait=0 after that cycle; every cycle exactly one car lamp and one ped lamp high.
